// File: rtl/hex_display_scanner_pkg.sv
// hex_display_pkg: segment patterns and scan states shared by the hex display scanner.
package hex_display_pkg;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    // Index is the nibble value, bit order is {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if: parallel word in, multiplexed seven-segment drive out.
interface hex_display_scanner_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
);
    logic [WIDTH-1:0]  value;
    logic [DIGITS-1:0] dp_mask;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;
    modport master (output value, dp_mask, input seg, dp, an);
    modport slave  (input value, dp_mask, output seg, dp, an);
endinterface

// File: rtl/hex_display_scanner_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment pattern.
module hex_to_seg
    import hex_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nib];
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: scans a latched word as hex digits on a common-anode display with blank gaps.
// Optional leading-zero blanking when HEX_DISPLAY_LZB_EN is defined.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int WIDTH        = 16,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic                 clk_100MHz,
    input logic                 rst_n,
    hex_display_scanner_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    if (WIDTH != 4 * DIGITS) begin : g_bad_width
        $error("WIDTH must equal 4*DIGITS");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be in 0..REFRESH_DIV-1");
    end

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  shadow, cur;
    logic [DIGITS-1:0] shadow_dp, cur_dp;
    logic [6:0]        dec;
    logic              load, in_show, lz_blank;
    state_t            mode;

    // The frame's first slot decodes the word being latched on that same edge.
    assign load   = cnt == '0 && idx == '0;
    assign cur    = load ? bus.value : shadow;
    assign cur_dp = load ? bus.dp_mask : shadow_dp;

    if (BLANK_CYCLES == 0) begin : g_no_gap
        assign in_show = 1'b1;
    end else begin : g_gap
        assign in_show = cnt >= CW'(BLANK_CYCLES);
    end

`ifdef HEX_DISPLAY_LZB_EN
    logic [DIGITS-1:0] lz;
    for (genvar i = 0; i < DIGITS; i++) begin : g_lz
        assign lz[i] = cur[WIDTH-1:4*i] == '0;
    end
    assign lz_blank = idx != '0 && lz[idx];
`else
    assign lz_blank = 1'b0;
`endif

    assign mode = in_show && !lz_blank ? SHOW : BLANK;

    hex_to_seg u_dec (.nib(cur[idx*4 +: 4]), .seg(dec));

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            bus.an    <= '1;
            bus.seg   <= SEG_OFF;
            bus.dp    <= 1'b1;
        end else begin
            cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
            if (cnt == CNT_MAX) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
            if (load) begin
                shadow    <= bus.value;
                shadow_dp <= bus.dp_mask;
            end
            bus.an  <= mode == SHOW ? ~(DIGITS'(1) << idx) : '1;
            bus.seg <= mode == SHOW ? dec : SEG_OFF;
            bus.dp  <= mode == SHOW ? ~cur_dp[idx] : 1'b1;
        end
    end
endmodule
